// File: rtl/reorder_stage_ctrl_pkg.sv
// rtl/reorder_stage_ctrl_pkg.sv - shared decode constants for the short-block reorder stage
//
// Purpose: constants and helpers shared by the reorder stage controller and
// any sibling stage controllers that walk (granule, channel) units.
//   NUM_GRANULES  granules per MPEG-1 frame
//   MODE_MONO     header channel-mode code for a single channel
//   BLOCK_SHORT   block_type code for short blocks
//   unit_idx()    packs (gr, ch) into the side-info unit index u = gr*2 + ch

package reorder_stage_ctrl_pkg;

  localparam int         NUM_GRANULES = 2;
  localparam logic [1:0] MODE_MONO    = 2'd3;
  localparam logic [1:0] BLOCK_SHORT  = 2'd2;

  // u = gr*2 + ch; with one bit each this is a plain concatenation.
  function automatic logic [1:0] unit_idx(input logic gr, input logic ch);
    return {gr, ch};
  endfunction

  function automatic logic is_short_block(input logic [1:0] block_type);
    return block_type == BLOCK_SHORT;
  endfunction

endpackage

// File: rtl/reorder_stage_ctrl_if.sv
// rtl/reorder_stage_ctrl_if.sv - pipeline, side-info and channel-unit signals of the reorder stage
//
// Purpose: bundles every non-clock signal of the reorder stage controller.
//   stage_ready / stage_done / stage_error / busy   pipeline handshake
//   header_mode, sideinfo_*_all                      frame header and side info
//   granule_bank_sel, ch_*                           per-unit selection to the channel unit
//   channel_ready / channel_done                     channel unit handshake
// Modports:
//   master  the controller's view
//   slave   the surrounding pipeline / channel unit view

interface reorder_stage_ctrl_if;

  logic       stage_ready;
  logic       stage_done;
  logic       stage_error;
  logic       busy;

  logic [1:0] header_mode;
  logic [7:0] sideinfo_block_type_all;
  logic [3:0] sideinfo_window_switching_all;
  logic [3:0] sideinfo_mixed_block_all;

  logic [1:0] granule_bank_sel;
  logic [1:0] ch_block_type;
  logic       ch_window_switching_flag;
  logic       ch_mixed_block_flag;
  logic       channel_ready;
  logic       channel_done;

  modport master (
    input  stage_ready,
    output stage_done,
    output stage_error,
    output busy,
    input  header_mode,
    input  sideinfo_block_type_all,
    input  sideinfo_window_switching_all,
    input  sideinfo_mixed_block_all,
    output granule_bank_sel,
    output ch_block_type,
    output ch_window_switching_flag,
    output ch_mixed_block_flag,
    output channel_ready,
    input  channel_done
  );

  modport slave (
    output stage_ready,
    input  stage_done,
    input  stage_error,
    input  busy,
    output header_mode,
    output sideinfo_block_type_all,
    output sideinfo_window_switching_all,
    output sideinfo_mixed_block_all,
    input  granule_bank_sel,
    input  ch_block_type,
    input  ch_window_switching_flag,
    input  ch_mixed_block_flag,
    input  channel_ready,
    output channel_done
  );

endinterface

// File: rtl/reorder_stage_ctrl_watchdog.sv
// rtl/reorder_stage_ctrl_watchdog.sv - cycle watchdog counter with clear, enable and expiry flag
//
// Purpose: counts enabled cycles since the last clear; expired is high while
// the count equals TIMEOUT_CYCLES-1, so a caller checking it on every enabled
// cycle allows exactly TIMEOUT_CYCLES enabled cycles before aborting.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        zero the counter (has priority over en)
//   en         advance the counter by one
//   expired    count has reached TIMEOUT_CYCLES-1

module reorder_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMER_W        = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/reorder_stage_ctrl.sv
// rtl/reorder_stage_ctrl.sv - sequencer walking (granule, channel) units through the reorder channel unit
//
// Purpose: on stage_ready, visits every (gr, ch) unit of the frame (2 for mono,
// 4 otherwise); for each unit registers the bank select and side-info fields,
// pulses channel_ready, and waits for channel_done under a watchdog. Ends the
// frame with a stage_done pulse, stage_error flagging a watchdog abort.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        reorder_stage_ctrl_if.master (handshakes, side info, unit selection)

module reorder_stage_ctrl
  import reorder_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMER_W        = 13
) (
  input logic                  clk,
  input logic                  rst,
  reorder_stage_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0] state_q, state_d;
  logic [1:0] nch_q, nch_d;
  logic       gr_q, gr_d;
  logic       ch_q, ch_d;
  logic       err_q, err_d;

  logic       busy_q, busy_d;
  logic       stage_done_q, stage_done_d;
  logic       stage_error_q, stage_error_d;
  logic       channel_ready_q, channel_ready_d;
  logic [1:0] granule_bank_sel_q, granule_bank_sel_d;
  logic [1:0] ch_block_type_q, ch_block_type_d;
  logic       ch_window_switching_flag_q, ch_window_switching_flag_d;
  logic       ch_mixed_block_flag_q, ch_mixed_block_flag_d;

  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;
  logic [1:0] unit;

  assign unit = unit_idx(gr_q, ch_q);

  reorder_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d                    = state_q;
    nch_d                      = nch_q;
    gr_d                       = gr_q;
    ch_d                       = ch_q;
    err_d                      = err_q;
    busy_d                     = busy_q;
    stage_done_d               = 1'b0;
    stage_error_d              = 1'b0;
    channel_ready_d            = 1'b0;
    // The channel unit decodes these combinationally for its whole run, so
    // they only ever change in SETUP.
    granule_bank_sel_d         = granule_bank_sel_q;
    ch_block_type_d            = ch_block_type_q;
    ch_window_switching_flag_d = ch_window_switching_flag_q;
    ch_mixed_block_flag_d      = ch_mixed_block_flag_q;
    wd_clr                     = 1'b0;
    wd_en                      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // channel_done is meaningless here and deliberately ignored.
        if (bus.stage_ready) begin
          nch_d   = (bus.header_mode == MODE_MONO) ? 2'd1 : 2'd2;
          gr_d    = 1'b0;
          ch_d    = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        granule_bank_sel_d         = unit;
        ch_block_type_d            = bus.sideinfo_block_type_all[{unit, 1'b0} +: 2];
        ch_window_switching_flag_d = bus.sideinfo_window_switching_all[unit];
        ch_mixed_block_flag_d      = bus.sideinfo_mixed_block_all[unit];
        state_d                    = ST_LAUNCH;
      end

      ST_LAUNCH: begin
        channel_ready_d = 1'b1;
        wd_clr          = 1'b1;
        state_d         = ST_WAIT;
      end

      ST_WAIT: begin
        wd_en = 1'b1;
        // A completion arriving on the expiry cycle still counts as success.
        if (bus.channel_done) begin
          state_d = ST_NEXT;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_NEXT: begin
        if ((2'(ch_q) + 2'd1) < nch_q) begin
          ch_d    = 1'b1;
          state_d = ST_SETUP;
        end else if ((32'(gr_q) + 32'd1) < 32'(NUM_GRANULES)) begin
          gr_d    = 1'b1;
          ch_d    = 1'b0;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        stage_done_d  = 1'b1;
        stage_error_d = err_q;
        busy_d        = 1'b0;
        err_d         = 1'b0;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                    <= ST_IDLE;
      nch_q                      <= 2'd0;
      gr_q                       <= 1'b0;
      ch_q                       <= 1'b0;
      err_q                      <= 1'b0;
      busy_q                     <= 1'b0;
      stage_done_q               <= 1'b0;
      stage_error_q              <= 1'b0;
      channel_ready_q            <= 1'b0;
      granule_bank_sel_q         <= 2'd0;
      ch_block_type_q            <= 2'd0;
      ch_window_switching_flag_q <= 1'b0;
      ch_mixed_block_flag_q      <= 1'b0;
    end else begin
      state_q                    <= state_d;
      nch_q                      <= nch_d;
      gr_q                       <= gr_d;
      ch_q                       <= ch_d;
      err_q                      <= err_d;
      busy_q                     <= busy_d;
      stage_done_q               <= stage_done_d;
      stage_error_q              <= stage_error_d;
      channel_ready_q            <= channel_ready_d;
      granule_bank_sel_q         <= granule_bank_sel_d;
      ch_block_type_q            <= ch_block_type_d;
      ch_window_switching_flag_q <= ch_window_switching_flag_d;
      ch_mixed_block_flag_q      <= ch_mixed_block_flag_d;
    end
  end

  assign bus.busy                     = busy_q;
  assign bus.stage_done               = stage_done_q;
  assign bus.stage_error              = stage_error_q;
  assign bus.channel_ready            = channel_ready_q;
  assign bus.granule_bank_sel         = granule_bank_sel_q;
  assign bus.ch_block_type            = ch_block_type_q;
  assign bus.ch_window_switching_flag = ch_window_switching_flag_q;
  assign bus.ch_mixed_block_flag      = ch_mixed_block_flag_q;

endmodule

// File: tb/tb_reorder_stage_ctrl.sv
// tb/tb_reorder_stage_ctrl.sv - directed self-checking bench for reorder_stage_ctrl

module tb_reorder_stage_ctrl;

  logic clk = 1'b0;
  logic rst;

  reorder_stage_ctrl_if bus();

  reorder_stage_ctrl #(
    .TIMEOUT_CYCLES (16),
    .TIMER_W        (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cr_count = 0;
  int sd_count = 0;

  // {bank_sel, block_type, window_switching, mixed} expected per unit for
  // block_type_all=10_00_10_00, window_switching_all=0101, mixed_all=0100.
  logic [5:0] exp_f [4];

  always @(negedge clk) begin
    if (bus.channel_ready === 1'b1) cr_count++;
    if (bus.stage_done === 1'b1) sd_count++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] fields();
    return {bus.granule_bank_sel, bus.ch_block_type,
            bus.ch_window_switching_flag, bus.ch_mixed_block_flag};
  endfunction

  task automatic start_frame(input logic [1:0] mode);
    bus.header_mode = mode;
    bus.stage_ready = 1'b1;
    tick();
    bus.stage_ready = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_cr(output int lat, output logic [5:0] prev);
    lat = 0;
    do begin
      prev = fields();
      tick();
      lat++;
    end while (bus.channel_ready !== 1'b1 && lat < 40);
    check("channel_ready_seen", 32'(bus.channel_ready), 32'd1);
  endtask

  // Waits for channel_ready, checks the unit selection, answers channel_done
  // 'delay' cycles later; optionally pokes stage_ready while the unit runs.
  task automatic run_unit(input logic [5:0] exp, input int delay, input bit poke, input int exp_lat);
    int         lat;
    logic [5:0] prev;
    wait_cr(lat, prev);
    check("unit_latency", 32'(lat), 32'(exp_lat));
    check("fields_before_ready", 32'(prev), 32'(exp));
    check("fields_at_ready", 32'(fields()), 32'(exp));
    check("busy_during_unit", 32'(bus.busy), 32'd1);
    for (int i = 0; i < delay; i++) begin
      bus.stage_ready = poke && (i == 1);
      tick();
      if (i == 0) check("ready_one_cycle", 32'(bus.channel_ready), 32'd0);
    end
    bus.stage_ready  = 1'b0;
    bus.channel_done = 1'b1;
    check("fields_held_to_done", 32'(fields()), 32'(exp));
    tick();
    bus.channel_done = 1'b0;
  endtask

  task automatic finish_frame(input logic exp_err);
    tick();
    check("no_done_yet", 32'(bus.stage_done), 32'd0);
    check("busy_before_done", 32'(bus.busy), 32'd1);
    tick();
    check("stage_done", 32'(bus.stage_done), 32'd1);
    check("stage_error", 32'(bus.stage_error), 32'(exp_err));
    check("busy_cleared", 32'(bus.busy), 32'd0);
    tick();
    check("stage_done_pulse", 32'(bus.stage_done), 32'd0);
  endtask

  initial begin
    int         cr_snap;
    int         sd_snap;
    int         lat;
    logic [5:0] prev;

    exp_f[0] = 6'b00_00_1_0;
    exp_f[1] = 6'b01_10_0_0;
    exp_f[2] = 6'b10_00_1_1;
    exp_f[3] = 6'b11_10_0_0;

    rst                               = 1'b1;
    bus.stage_ready                   = 1'b0;
    bus.channel_done                  = 1'b0;
    bus.header_mode                   = 2'd0;
    bus.sideinfo_block_type_all       = 8'b10_00_10_00;
    bus.sideinfo_window_switching_all = 4'b0101;
    bus.sideinfo_mixed_block_all      = 4'b0100;
    repeat (3) tick();
    check("reset_outputs", {22'd0, bus.stage_done, bus.stage_error, bus.busy,
                            bus.channel_ready, fields()}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Stereo frame: four units, banks 0..3; unit 1 answers with zero latency.
    start_frame(2'd0);
    run_unit(exp_f[0], 10, 1'b0, 2);
    run_unit(exp_f[1], 0, 1'b0, 3);
    run_unit(exp_f[2], 10, 1'b0, 3);
    run_unit(exp_f[3], 10, 1'b0, 3);
    finish_frame(1'b0);
    repeat (3) tick();

    // Mono frame: banks 0 and 2 only; done exactly on the watchdog expiry cycle wins.
    cr_snap = cr_count;
    start_frame(2'd3);
    run_unit(exp_f[0], 15, 1'b0, 2);
    run_unit(exp_f[2], 15, 1'b0, 3);
    finish_frame(1'b0);
    tick();
    check("mono_two_runs", 32'(cr_count - cr_snap), 32'd2);
    repeat (2) tick();

    // Watchdog abort: unit 1 never completes.
    start_frame(2'd0);
    run_unit(exp_f[0], 3, 1'b0, 2);
    wait_cr(lat, prev);
    check("abort_unit_fields", 32'(fields()), 32'(exp_f[1]));
    tick();
    cr_snap = cr_count;
    repeat (15) tick();
    check("abort_not_early", 32'(bus.stage_done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    tick();
    check("abort_done", 32'(bus.stage_done), 32'd1);
    check("abort_error", 32'(bus.stage_error), 32'd1);
    check("abort_busy_cleared", 32'(bus.busy), 32'd0);
    repeat (8) tick();
    check("abort_no_more_ready", 32'(cr_count - cr_snap), 32'd0);
    check("abort_fields_kept", 32'(fields()), 32'(exp_f[1]));

    // Spurious channel_done in IDLE, then stage_ready poked while busy.
    bus.channel_done = 1'b1;
    tick();
    bus.channel_done = 1'b0;
    repeat (3) tick();
    check("idle_done_ignored", {30'd0, bus.busy, bus.channel_ready}, 32'd0);
    cr_snap = cr_count;
    sd_snap = sd_count;
    start_frame(2'd0);
    run_unit(exp_f[0], 10, 1'b1, 2);
    run_unit(exp_f[1], 10, 1'b0, 3);
    run_unit(exp_f[2], 10, 1'b0, 3);
    run_unit(exp_f[3], 10, 1'b1, 3);
    finish_frame(1'b0);
    repeat (6) tick();
    check("busy_start_not_queued", 32'(cr_count - cr_snap), 32'd4);
    check("one_frame_done", 32'(sd_count - sd_snap), 32'd1);
    check("idle_after_frame", 32'(bus.busy), 32'd0);

    // Reset during WAIT of unit 2, then a fresh full frame.
    start_frame(2'd0);
    run_unit(exp_f[0], 10, 1'b0, 2);
    run_unit(exp_f[1], 10, 1'b0, 3);
    wait_cr(lat, prev);
    repeat (3) tick();
    sd_snap = sd_count;
    rst = 1'b1;
    tick();
    check("midframe_reset_outputs", {22'd0, bus.stage_done, bus.stage_error, bus.busy,
                                     bus.channel_ready, fields()}, 32'd0);
    rst = 1'b0;
    repeat (25) tick();
    check("reset_no_stage_done", 32'(sd_count - sd_snap), 32'd0);
    check("reset_idle", {30'd0, bus.busy, bus.channel_ready}, 32'd0);
    start_frame(2'd0);
    run_unit(exp_f[0], 10, 1'b0, 2);
    run_unit(exp_f[1], 10, 1'b0, 3);
    run_unit(exp_f[2], 10, 1'b0, 3);
    run_unit(exp_f[3], 10, 1'b0, 3);
    finish_frame(1'b0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_stage_ctrl.md
Name: reorder_stage_ctrl

Overview:
Sequencer for the per-channel short-block reorder unit in the MP3 decode pipeline. On a stage-level start it walks every (granule, channel) pair of the frame: 2 pairs for mono, 4 otherwise. For each pair it selects the granule RAM bank and presents that pair's side-info fields. It then starts the channel unit and waits for its completion. It reports frame completion, or a watchdog error, to the pipeline handshake.

Parameters:
NUM_GRANULES, 2, granules per frame (MPEG-1)
TIMEOUT_CYCLES, 4096, maximum cycles allowed between channel_ready and channel_done
TIMER_W, 13, watchdog counter width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stage_ready  in  1  one-cycle start pulse from the previous stage
stage_done  out  1  one-cycle pulse when the frame finishes or aborts
stage_error  out  1  valid with stage_done; 1 = watchdog abort
busy  out  1  high from accepted start until stage_done
header_mode  in  2  channel mode; 3 = mono (1 channel)
sideinfo_block_type_all  in  8  block_type for unit index u=gr*2+ch, bits [2u+1:2u]
sideinfo_window_switching_all  in  4  window_switching_flag, bit u
sideinfo_mixed_block_all  in  4  mixed_block_flag, bit u
granule_bank_sel  out  2  {gr,ch}; selects the granule RAM bank seen by the channel unit
ch_block_type  out  2  selected block_type
ch_window_switching_flag  out  1  selected flag
ch_mixed_block_flag  out  1  selected flag
channel_ready  out  1  one-cycle start pulse to the channel unit
channel_done  in  1  one-cycle completion pulse from the channel unit

Behaviour:
- All outputs registered. Reset values:
  - state IDLE.
  - stage_done, stage_error, busy, channel_ready = 0.
  - granule_bank_sel = 0.
  - ch_* = 0.
- States: IDLE, SETUP, LAUNCH, WAIT, NEXT, DONE.
- IDLE:
  - stage_ready=1 → latch nch = (header_mode==3) ? 1 : 2; gr=0, ch=0; busy<=1; go to SETUP.
  - channel_done in IDLE is ignored.
- SETUP:
  - Register granule_bank_sel={gr,ch} and the three ch_* fields indexed by u={gr,ch}.
  - Go to LAUNCH. Selected fields are therefore stable at least one cycle before channel_ready.
- LAUNCH: channel_ready<=1 for exactly one cycle; clear timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - channel_done=1 → NEXT.
  - Otherwise, timer==TIMEOUT_CYCLES-1 → set error flag, go to DONE.
  - channel_done in the same cycle as expiry: done wins, no error.
- NEXT:
  - If ch+1<nch: ch++, go to SETUP.
  - Else if gr+1<NUM_GRANULES: gr++, ch=0, go to SETUP.
  - Else go to DONE.
- DONE:
  - stage_done<=1 for one cycle; stage_error<=error flag in the same cycle.
  - busy<=0; clear error flag; go to IDLE.
- granule_bank_sel and ch_* hold their values from SETUP until the next SETUP. The channel unit decodes its block mode combinationally and requires them stable through its whole run. They are not cleared in DONE.
- stage_ready while busy: ignored, not queued.
- header_mode and side-info inputs are sampled only in IDLE (nch) and SETUP (fields). Changes mid-frame affect only later SETUPs.
- Latency with zero-latency channel_done: stage_ready → first channel_ready = 3 cycles. Per unit = 4 + channel run cycles.
- Reset mid-operation returns to IDLE next edge with all outputs at reset values. No stage_done is emitted for the aborted frame.

Decomposition:
- Shared decode package holds:
  - channel-mode constant MODE_MONO=3.
  - block_type constant BLOCK_SHORT=2.
  - NUM_GRANULES.
  - unit-index packing function u=gr*2+ch.
- Sub-module reorder_watchdog: a counter with clear, enable and expiry output, parameterised by TIMEOUT_CYCLES/TIMER_W. Reusable by the other stage controllers.

Test Plan:
- Stereo (header_mode=0), channel_done 10 cycles after each channel_ready → four channel_ready pulses with granule_bank_sel 0,1,2,3, then stage_done=1, stage_error=0; busy high throughout.
- Mono (header_mode=3) → exactly two runs with bank_sel 0 then 2; stage_done after the second channel_done.
- block_type_all=8'b10_00_10_00, window_switching_all=4'b0101, mixed_all=4'b0100:
  - per-unit ch_* = (0,1,0), (2,0,0), (0,1,1), (2,0,0).
  - ch_* stable from one cycle before each channel_ready until the next SETUP.
- TIMEOUT_CYCLES=16, channel_done withheld on unit 1 → abort 16 cycles after that channel_ready; stage_done=1 with stage_error=1; no further channel_ready pulses.
- stage_ready pulsed while busy, and channel_done pulsed in IDLE → no effect; one frame completes normally.
- rst asserted during WAIT of unit 2 → next cycle all outputs 0, state IDLE, no stage_done; a fresh stage_ready runs a full frame starting at bank_sel 0.
